// File: rtl/systolic_operand_feeder.sv
// Operand feeder for one edge of a systolic PE array: buffers a DIM x DIM
// operand matrix and streams it as diagonally skewed lanes plus accumulate-enable.
module systolic_operand_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int DIM        = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          wr_en_i,
  input  logic [$clog2(DIM)-1:0]        wr_row_i,
  input  logic [$clog2(DIM)-1:0]        wr_col_i,
  input  logic signed [DATA_WIDTH-1:0]  wr_data_i,
  input  logic                          go_i,
  input  logic                          release_i,
  output logic                          busy_o,
  output logic                          start_o,
  output logic                          done_o,
  output logic [DIM*DATA_WIDTH-1:0]     data_o
);

  localparam int AW        = $clog2(DIM);
  localparam int CW        = $clog2(3*DIM);
  localparam int FEED_LAST = 3*DIM - 3;

  if (DIM < 2 || (DIM & (DIM - 1)) != 0) begin : g_bad_dim
    $error("systolic_operand_feeder: DIM must be a power of 2 and at least 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                cnt, cnt_nxt;
  logic                         busy_nxt, start_nxt, done_nxt;
  logic [DIM*DATA_WIDTH-1:0]    lanes_nxt;
  logic                         wr_ok;
  logic signed [DATA_WIDTH-1:0] mem [DIM][DIM];

  // A go in the same cycle wins over a write, so the pass sees a stable buffer.
  assign wr_ok = (state == IDLE) && wr_en_i && !go_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          mem[r][c] <= '0;
        end
      end
    end else if (wr_ok) begin
      mem[wr_row_i][wr_col_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (go_i) begin
          state_nxt = FEED;
          cnt_nxt   = '0;
        end
      end
      FEED: begin
        if (cnt == CW'(FEED_LAST)) begin
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (release_i) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are computed for the upcoming state and registered, so lane 0
  // shows mem[0][0] in the first FEED cycle with no input-to-output path.
  always_comb begin
    int k;
    k         = 0;
    busy_nxt  = (state_nxt == FEED) || (state_nxt == HOLD);
    start_nxt = busy_nxt;
    done_nxt  = (state_nxt == HOLD);
    lanes_nxt = '0;
    if (state_nxt == FEED) begin
      for (int l = 0; l < DIM; l++) begin
        k = int'(cnt_nxt) - l;
        if (k >= 0 && k < DIM) begin
          lanes_nxt[l*DATA_WIDTH +: DATA_WIDTH] = mem[l][k[AW-1:0]];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_o  <= 1'b0;
      start_o <= 1'b0;
      done_o  <= 1'b0;
      data_o  <= '0;
    end else begin
      busy_o  <= busy_nxt;
      start_o <= start_nxt;
      done_o  <= done_nxt;
      data_o  <= lanes_nxt;
    end
  end

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Directed bench for systolic_operand_feeder: skew timing, hold/release,
// write protection, signed PE(0,0) integration and mid-pass reset.
module tb_systolic_operand_feeder;

  localparam int DW = 32;
  localparam int N  = 4;

  logic              clk;
  logic              rst_n;
  logic              wr_en, wr_en_b;
  logic [1:0]        wr_row, wr_col;
  logic signed [DW-1:0] wr_data;
  logic              go, go_b, rel, rel_b;
  logic              busy_a, start_a, done_a;
  logic              busy_b, start_b, done_b;
  logic [N*DW-1:0]   data_a, data_b;

  int errors = 0;
  int checks = 0;

  systolic_operand_feeder #(.DATA_WIDTH(DW), .DIM(N)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_row_i(wr_row),
    .wr_col_i(wr_col), .wr_data_i(wr_data), .go_i(go), .release_i(rel),
    .busy_o(busy_a), .start_o(start_a), .done_o(done_a), .data_o(data_a)
  );

  systolic_operand_feeder #(.DATA_WIDTH(DW), .DIM(N)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en_b), .wr_row_i(wr_row),
    .wr_col_i(wr_col), .wr_data_i(wr_data), .go_i(go_b), .release_i(rel_b),
    .busy_o(busy_b), .start_o(start_b), .done_o(done_b), .data_o(data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PE(0,0): accumulates while start is high, clears while low.
  logic signed [DW-1:0] a0, b0;
  logic signed [63:0]   acc;
  assign a0 = data_a[DW-1:0];
  assign b0 = data_b[DW-1:0];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        acc <= '0;
    else if (!start_a) acc <= '0;
    else               acc <= acc + a0 * b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Skew pattern for mem[l][k] = 16*l + k + 1.
  function automatic logic [DW-1:0] exp_lane(input int c, input int l);
    int k;
    k = c - l;
    if (k >= 0 && k < N) return DW'(16*l + k + 1);
    return '0;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".busy"},  busy_a,  1'b0);
    check({tag, ".start"}, start_a, 1'b0);
    check({tag, ".done"},  done_a,  1'b0);
    check({tag, ".data"},  data_a,  '0);
  endtask

  task automatic check_hold(input string tag);
    check({tag, ".busy"},  busy_a,  1'b1);
    check({tag, ".start"}, start_a, 1'b1);
    check({tag, ".done"},  done_a,  1'b1);
    check({tag, ".data"},  data_a,  '0);
  endtask

  // Checks one FEED cycle; zero_mem selects the all-zero buffer expectation.
  task automatic check_feed(input int c, input bit zero_mem);
    check($sformatf("feed%0d.start", c), start_a, 1'b1);
    check($sformatf("feed%0d.busy", c),  busy_a,  1'b1);
    check($sformatf("feed%0d.done", c),  done_a,  1'b0);
    for (int l = 0; l < N; l++) begin
      check($sformatf("feed%0d.lane%0d", c, l), data_a[l*DW +: DW],
            zero_mem ? '0 : exp_lane(c, l));
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_en_b = 1'b0; wr_row = '0; wr_col = '0;
    wr_data = '0; go = 1'b0; go_b = 1'b0; rel = 1'b0; rel_b = 1'b0;

    // Reset and idle
    #3;
    check_idle("in_reset");
    #19 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_idle("idle_after_reset");

    // Load mem[l][k] = 16*l + k + 1
    for (int l = 0; l < N; l++) begin
      for (int k = 0; k < N; k++) begin
        wr_en = 1'b1; wr_row = 2'(l); wr_col = 2'(k); wr_data = DW'(16*l + k + 1);
        tick();
      end
    end
    wr_en = 1'b0;
    check_idle("idle_after_writes");

    // First pass; a write during FEED must be dropped
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int c = 0; c < 3*N-2; c++) begin
      check_feed(c, 1'b0);
      if (c == 0) begin
        wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 32'sd99;
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      check_hold($sformatf("hold%0d", i));
      tick();
    end
    rel = 1'b1;
    tick();
    rel = 1'b0;
    check_idle("after_release");

    // Second pass: write alongside go is dropped; release during FEED ignored
    go = 1'b1; wr_en = 1'b1; wr_row = 2'd1; wr_col = 2'd1; wr_data = 32'sd77;
    tick();
    go = 1'b0; wr_en = 1'b0;
    for (int c = 0; c < 3*N-2; c++) begin
      check_feed(c, 1'b0);
      rel = (c == 2);
      tick();
    end
    rel = 1'b0;
    check_hold("hold_pass2");

    // go with release in HOLD: release wins, go is not queued
    go = 1'b1; rel = 1'b1;
    tick();
    go = 1'b0; rel = 1'b0;
    check_idle("go_rel_same_cycle");
    tick();
    tick();
    check_idle("go_not_queued");

    // Integration: A row 0 = {-1,2,-3,4}, B column 0 = {5,6,7,8}
    for (int k = 0; k < N; k++) begin
      wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'(k);
      wr_data = (k % 2 == 0) ? -(k + 1) : (k + 1);
      tick();
    end
    wr_en = 1'b0;
    for (int k = 0; k < N; k++) begin
      wr_en_b = 1'b1; wr_row = 2'd0; wr_col = 2'(k); wr_data = DW'(k + 5);
      tick();
    end
    wr_en_b = 1'b0;
    go = 1'b1; go_b = 1'b1;
    tick();
    go = 1'b0; go_b = 1'b0;
    check("int.a_lane0_neg", data_a[DW-1:0], 32'hFFFF_FFFF);
    check("int.b_lane0", data_b[DW-1:0], 32'd5);
    tick();
    tick();
    check("int.a_lane0_c2", data_a[DW-1:0], 32'hFFFF_FFFD);
    for (int i = 0; i < 3*N-4; i++) tick();
    check("int.done_a", done_a, 1'b1);
    check("int.done_b", done_b, 1'b1);
    check("int.pe00", acc, 64'd18);
    rel = 1'b1; rel_b = 1'b1;
    tick();
    rel = 1'b0; rel_b = 1'b0;
    check_idle("int_release");
    check("int.busy_b", busy_b, 1'b0);

    // Reset mid-pass at FEED cycle 4
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_reset.busy", busy_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    #2 rst_n = 1'b1;
    tick();
    check_idle("post_reset_idle");
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int c = 0; c < 3*N-2; c++) begin
      check_feed(c, 1'b1);
      tick();
    end
    check_hold("hold_after_reset");
    rel = 1'b1;
    tick();
    rel = 1'b0;
    check_idle("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
